// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read-side drain controller for the FIFO.
// Pops words with Read_enable, captures the returned data one cycle later
// into a two-entry head/spare buffer and presents it on a valid/ready stream.
// Keeping occ + inflight <= 2 lets the block stream one word per cycle
// without ever overrunning the buffer, even under backpressure.
module fifo_read_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_read,
  input  logic                  a_Reset,
  input  logic                  drain_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  Read_enable,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  busy
);

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] spare_q, spare_d;
  logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;
  logic                  pop;
  logic [1:0]            level;

  // A word leaves whenever the head is valid and downstream accepts it.
  // level is the buffer occupancy after this cycle's capture and pop; it
  // never exceeds 2, so two bits suffice.
  assign pop   = (occ_q != 2'd0) & m_ready;
  assign level = occ_q + {1'b0, inflight_q} - {1'b0, pop};

  // Issuing only when level < 2 guarantees a free slot when the data returns;
  // counting this cycle's pop as credit is what sustains one word per cycle.
  assign Read_enable = !a_Reset & drain_en & !fifo_empty & (level < 2'd2);

  // Next-state for buffer, occupancy, in-flight flag and delivered counter.
  always_comb begin
    occ_d      = level;
    inflight_d = Read_enable;
    head_d     = head_q;
    spare_d    = spare_q;
    rd_count_d = rd_count_q + CNT_WIDTH'(pop);
    if (pop && (occ_q == 2'd2)) begin
      head_d = spare_q;
    end
    if (inflight_q) begin
      if ((occ_q == 2'd0) || pop) begin
        head_d = fifo_data;
      end else begin
        spare_d = fifo_data;
      end
    end
  end

  // State registers with synchronous reset; reset drops any buffered or in-flight word.
  always_ff @(posedge clk_read) begin
    if (a_Reset) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      spare_q    <= '0;
      rd_count_q <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      spare_q    <= spare_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign m_valid  = (occ_q != 2'd0);
  assign m_data   = head_q;
  assign rd_count = rd_count_q;
  assign busy     = (occ_q != 2'd0) | inflight_q;

  // A capture can never coincide with a full buffer, and occupancy never reaches 3.
  occ_bound_a: assert property (@(posedge clk_read) disable iff (a_Reset)
    !(inflight_q && (occ_q == 2'd2)) && (occ_q != 2'd3));

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb_fifo_read_ctrl: scoreboard bench for fifo_read_ctrl.
// A queue models the FIFO contents; every word the FIFO hands out is pushed
// to an expected queue, which a monitor pops on each downstream handshake.
module tb_fifo_read_ctrl;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk_read = 1'b0;
  logic          a_Reset = 1'b1;
  logic          drain_en = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          Read_enable;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [CW-1:0] rd_count;
  logic          busy;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [CW-1:0] exp_count = '0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;
  logic          rst_last = 1'b1;
  logic          re_s = 1'b0;
  logic          rst_s = 1'b1;

  fifo_read_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_read    (clk_read),
    .a_Reset     (a_Reset),
    .drain_en    (drain_en),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .Read_enable (Read_enable),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .rd_count    (rd_count),
    .busy        (busy)
  );

  // Free-running read clock.
  always #5 clk_read = ~clk_read;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk_read);
    #1;
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(DW'($urandom));
    end
  endtask

  task automatic doReset();
    a_Reset = 1'b1;
    nextCycle();
    nextCycle();
    a_Reset = 1'b0;
  endtask

  // FIFO model plus scoreboard monitor: FIFO acts on the rising edge using
  // values captured at the falling edge, the monitor samples at the falling edge.
  always begin
    logic [DW-1:0] w;
    @(posedge clk_read);
    rst_last = rst_s;
    if (rst_s) begin
      exp_q.delete();
      exp_count = '0;
    end else if (re_s) begin
      checkOutput("no_empty_read", 32'(fifo_q.size() != 0), 1);
      if (fifo_q.size() != 0) begin
        w = fifo_q.pop_front();
        fifo_data <= w;
        exp_q.push_back(w);
      end
    end
    fifo_empty <= (fifo_q.size() == 0);

    @(negedge clk_read);
    if (a_Reset) checkOutput("rst_read_enable", 32'(Read_enable), 0);
    if (rst_last) begin
      checkOutput("rst_m_valid", 32'(m_valid), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_rd_count", 32'(rd_count), 0);
      checkOutput("rst_m_data", 32'(m_data), 0);
      stall_prev = 1'b0;
    end else begin
      checkOutput("busy", 32'(busy), 32'(exp_q.size() != 0));
      checkOutput("rd_count", 32'(rd_count), 32'(exp_count));
      checkOutput("outstanding_le2", 32'(exp_q.size() <= 2), 1);
      if (stall_prev) begin
        checkOutput("hold_valid", 32'(m_valid), 1);
        checkOutput("hold_data", 32'(m_data), 32'(stall_data));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
        end else begin
          checkOutput("data_order", 32'(m_data), 32'(exp_q.pop_front()));
        end
        exp_count = exp_count + 1'b1;
      end
      stall_prev = m_valid && !m_ready;
      stall_data = m_data;
    end
    re_s  = Read_enable;
    rst_s = a_Reset;
  end

  // Directed scenarios followed by a randomized run.
  initial begin
    int re_first, re_last, re_cnt, mv_first, mv_last, mv_cnt, pushed;
    logic [DW-1:0] next_word;
    logic seen;

    // Reset with data waiting, then a single word.
    a_Reset = 1'b1; drain_en = 1'b1; m_ready = 1'b1;
    fifo_q.push_back(8'h13);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_read);
      checkOutput("reset_re", 32'(Read_enable), 0);
      checkOutput("reset_valid", 32'(m_valid), 0);
      checkOutput("reset_busy", 32'(busy), 0);
      checkOutput("reset_count", 32'(rd_count), 0);
      nextCycle();
    end
    a_Reset = 1'b0;
    @(negedge clk_read);
    checkOutput("single_re_t", 32'(Read_enable), 1);
    nextCycle(); @(negedge clk_read);
    checkOutput("single_re_t1", 32'(Read_enable), 0);
    checkOutput("single_valid_t1", 32'(m_valid), 0);
    nextCycle(); @(negedge clk_read);
    checkOutput("single_valid_t2", 32'(m_valid), 1);
    checkOutput("single_data_t2", 32'(m_data), 32'h13);
    nextCycle(); @(negedge clk_read);
    checkOutput("single_valid_t3", 32'(m_valid), 0);
    checkOutput("single_count", 32'(rd_count), 1);
    checkOutput("single_re_t3", 32'(Read_enable), 0);
    nextCycle();

    // Streaming 34 words at full rate.
    doReset();
    applyStimulus(34);
    re_first = -1; re_last = -1; re_cnt = 0;
    mv_first = -1; mv_last = -1; mv_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk_read);
      if (Read_enable) begin
        if (re_first < 0) re_first = k;
        re_last = k; re_cnt++;
      end
      if (m_valid) begin
        if (mv_first < 0) mv_first = k;
        mv_last = k; mv_cnt++;
      end
      nextCycle();
    end
    checkOutput("stream_re_count", 32'(re_cnt), 34);
    checkOutput("stream_re_span", 32'(re_last - re_first + 1), 34);
    checkOutput("stream_valid_count", 32'(mv_cnt), 34);
    checkOutput("stream_valid_span", 32'(mv_last - mv_first + 1), 34);
    checkOutput("stream_latency", 32'(mv_first - re_first), 2);
    checkOutput("stream_rd_count", 32'(rd_count), 34);

    // Backpressure: 10 words, downstream stalls in cycles 4-8.
    doReset();
    applyStimulus(10);
    re_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      m_ready = !(k >= 4 && k <= 8);
      @(negedge clk_read);
      if (Read_enable) re_cnt++;
      nextCycle();
    end
    m_ready = 1'b1;
    checkOutput("bp_re_count", 32'(re_cnt), 10);
    checkOutput("bp_rd_count", 32'(rd_count), 10);

    // Empty FIFO: nothing may be read.
    doReset();
    re_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_read);
      if (Read_enable) re_cnt++;
      nextCycle();
    end
    checkOutput("empty_re_count", 32'(re_cnt), 0);

    // drain_en dropped mid-stream.
    doReset();
    applyStimulus(20);
    for (int k = 0; k < 6; k++) nextCycle();
    drain_en = 1'b0;
    @(negedge clk_read);
    checkOutput("drain_off_re", 32'(Read_enable), 0);
    re_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      nextCycle(); @(negedge clk_read);
      if (Read_enable) re_cnt++;
    end
    checkOutput("drain_off_re_count", 32'(re_cnt), 0);
    checkOutput("drain_off_busy", 32'(busy), 0);
    checkOutput("drain_off_count", 32'(rd_count), 32'(20 - fifo_q.size()));
    nextCycle();
    drain_en = 1'b1;
    for (int k = 0; k < 30; k++) nextCycle();
    checkOutput("drain_resume_count", 32'(rd_count), 20);

    // Reset while words are buffered and one is in flight.
    doReset();
    m_ready = 1'b0;
    applyStimulus(10);
    for (int k = 0; k < 6; k++) nextCycle();
    m_ready = 1'b1;
    nextCycle();
    m_ready = 1'b0;
    a_Reset = 1'b1;
    @(negedge clk_read);
    next_word = fifo_q[0];
    nextCycle();
    a_Reset = 1'b0;
    m_ready = 1'b1;
    @(negedge clk_read);
    checkOutput("midrst_valid", 32'(m_valid), 0);
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_count", 32'(rd_count), 0);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      nextCycle(); @(negedge clk_read);
      if (m_valid) begin
        seen = 1'b1;
        checkOutput("midrst_first_word", 32'(m_data), 32'(next_word));
      end
    end
    checkOutput("midrst_word_seen", 32'(seen), 1);
    for (int k = 0; k < 20; k++) nextCycle();
    checkOutput("midrst_rest_count", 32'(rd_count), 7);

    // Randomized run with random backpressure, drain_en and arrivals.
    doReset();
    pushed = 0;
    for (int k = 0; k < 400; k++) begin
      m_ready  = ($urandom_range(0, 3) != 0);
      drain_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 2) == 0) begin
        int n;
        n = $urandom_range(1, 3);
        applyStimulus(n);
        pushed += n;
      end
      nextCycle();
    end
    drain_en = 1'b1;
    m_ready  = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk_read);
      if (fifo_q.size() == 0 && fifo_empty && !busy) seen = 1'b1;
      else nextCycle();
    end
    checkOutput("random_drained", 32'(seen), 1);
    checkOutput("random_rd_count", 32'(rd_count), 32'(CW'(pushed)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
